// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Optional leading-zero suppression is enabled with `define LEADING_ZERO_BLANK_EN.
module display_scanner #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic [DIGITS-1:0]     blank,
   output logic [3:0]            num,
   output logic [DIGITS-1:0]     anode,
   output logic [2:0]            slot,
   output logic                  frame
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [2:0]    SLOT_LAST = 3'(DIGITS - 1);

   logic [4*DIGITS-1:0] shadow;
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [3:0]          nib [DIGITS];
   logic [DIGITS-1:0]   eff_blank;
   logic [DIGITS-1:0]   anode_next;
   logic                guard_done;
   logic                slot_end;

   assign slot_end = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
      end else if (load) begin
         shadow <= value;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         nib[i] = shadow[4*i +: 4];
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] lz;
   logic              upper_zero;

   // Walk down from the most significant digit; digit 0 always stays lit.
   always_comb begin
      lz         = '0;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         upper_zero = upper_zero & (nib[i] == 4'h0);
         lz[i]      = upper_zero;
      end
   end

   assign eff_blank = blank | lz;
`else
   assign eff_blank = blank;
`endif

   generate
      if (GUARD_CYCLES == 0) begin : g_no_guard
         assign guard_done = 1'b1;
      end else begin : g_guard
         assign guard_done = (cnt >= CW'(GUARD_CYCLES));
      end
   endgenerate

   always_comb begin
      anode_next = '1;
      if (guard_done && !eff_blank[idx]) begin
         anode_next[idx] = 1'b0;
      end
   end

   // Outputs lag cnt/idx by one cycle; frame fires when slot is about to
   // change from the last digit back to digit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num   <= '0;
         anode <= '1;
         slot  <= '0;
         frame <= 1'b0;
      end else begin
         num   <= nib[idx];
         anode <= anode_next;
         slot  <= 3'(idx);
         frame <= (cnt == '0) && (idx == '0) && (slot == SLOT_LAST);
      end
   end

endmodule
